// File: rtl/lfsr_pq_stim.sv
// Stimulus generator for the 16-bit priority queue.
// It pulls two bytes from the 8-bit LFSR, assembles a key, and chooses push or pop.
// It then offers the operation on a valid/ready handshake. It tracks queue
// occupancy so it never pushes into a full queue or pops from an empty one.
// KEY_W must stay at 16, which is two LFSR bytes.
module lfsr_pq_stim #(
    parameter int KEY_W    = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_OPS  = 64,
    localparam int OCC_W   = $clog2(DEPTH + 1),
    localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       rnd_i,
    output logic             rnd_enb_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic             op_push_o,
    output logic [KEY_W-1:0] op_key_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic [CNT_W-1:0] op_count_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        ISSUE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         key_hi_q, key_hi_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               push_q, push_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               handshake;

    assign handshake = (state_q == ISSUE) && op_ready_i;

    // State and datapath registers; reset returns everything to IDLE with all outputs cleared
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            key_hi_q <= '0;
            key_q    <= '0;
            push_q   <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_hi_q <= key_hi_d;
            key_q    <= key_d;
            push_q   <= push_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: fetch two bytes, pick a guarded direction, then hold the op until accepted
    always_comb begin
        state_d  = state_q;
        key_hi_d = key_hi_q;
        key_d    = key_q;
        push_d   = push_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = GET_HI;
                    cnt_d   = '0;
                end
            end
            GET_HI: begin
                key_hi_d = rnd_i;
                state_d  = GET_LO;
            end
            GET_LO: begin
                key_d = {key_hi_q, rnd_i};
                if (occ_q == '0) begin
                    push_d = 1'b1;
                end else if (occ_q == OCC_W'(DEPTH)) begin
                    push_d = 1'b0;
                end else begin
                    push_d = key_hi_q[7];
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                if (handshake) begin
                    occ_d   = push_q ? (occ_q + OCC_W'(1)) : (occ_q - OCC_W'(1));
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(NUM_OPS - 1)) ? DONE : GET_HI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: the LFSR only advances while a byte is being consumed
    always_comb begin
        rnd_enb_o  = 1'b0;
        op_valid_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            GET_HI:  begin rnd_enb_o = 1'b1; busy_o = 1'b1; end
            GET_LO:  begin rnd_enb_o = 1'b1; busy_o = 1'b1; end
            ISSUE:   begin op_valid_o = 1'b1; busy_o = 1'b1; end
            DONE:    begin done_o = 1'b1; busy_o = 1'b1; end
            default: busy_o = 1'b0;
        endcase
    end

    assign op_push_o   = push_q;
    assign op_key_o    = key_q;
    assign occupancy_o = occ_q;
    assign op_count_o  = cnt_q;

    // The direction guard must keep occupancy within 0..DEPTH
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        handshake |-> !(push_q && (occ_q == OCC_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        handshake |-> !(!push_q && (occ_q == '0)));
    a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        occ_q <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_lfsr_pq_stim.sv
// Testbench for lfsr_pq_stim.
// Instance A uses the default parameters and is fed an LFSR stream seeded with 0x01.
// Instance B uses DEPTH=2 and NUM_OPS=3. It starts on the same LFSR bytes and then
// switches to random bytes whose raw direction is always push, so the full guard is hit.
module tb_lfsr_pq_stim;

    localparam int DEPTH_A = 16;
    localparam int OPS_A   = 64;
    localparam int DEPTH_B = 2;
    localparam int OPS_B   = 3;

    typedef struct {
        logic [15:0] key;
        logic        isPush;
        int          occ;
        int          cnt;
        logic        last;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, startA, rndEnbA, validA, readyA, pushA, busyA, doneA;
    logic [7:0]  rndA;
    logic [15:0] keyA;
    logic [4:0]  occA;
    logic [6:0]  cntA;

    logic        rstB, startB, rndEnbB, validB, readyB, pushB, busyB, doneB;
    logic [7:0]  rndB;
    logic [15:0] keyB;
    logic [1:0]  occB;
    logic [1:0]  cntB;

    logic [7:0]  streamA [512];
    logic [7:0]  streamB [64];
    logic [8:0]  idxA = '0;
    logic [5:0]  idxB = '0;

    op_t  expA[$];
    op_t  expB[$];
    op_t  pendOpA, pendOpB;
    logic pendA = 1'b0;
    logic pendB = 1'b0;

    int assertCount = 0;
    int failCount   = 0;
    int doneCntA    = 0;
    int doneCntB    = 0;
    int obsGuard    = 0;
    int modelOcc[2];

    lfsr_pq_stim #(.KEY_W(16), .DEPTH(DEPTH_A), .NUM_OPS(OPS_A)) uDutA (
        .clk_i(clk), .rst_i(rstA), .start_i(startA), .rnd_i(rndA),
        .rnd_enb_o(rndEnbA), .op_valid_o(validA), .op_ready_i(readyA),
        .op_push_o(pushA), .op_key_o(keyA), .occupancy_o(occA),
        .op_count_o(cntA), .busy_o(busyA), .done_o(doneA)
    );

    lfsr_pq_stim #(.KEY_W(16), .DEPTH(DEPTH_B), .NUM_OPS(OPS_B)) uDutB (
        .clk_i(clk), .rst_i(rstB), .start_i(startB), .rnd_i(rndB),
        .rnd_enb_o(rndEnbB), .op_valid_o(validB), .op_ready_i(readyB),
        .op_push_o(pushB), .op_key_o(keyB), .occupancy_o(occB),
        .op_count_o(cntB), .busy_o(busyB), .done_o(doneB)
    );

    // Byte streams stand in for the LFSR and advance only when the DUT asks for it
    assign rndA = streamA[idxA];
    assign rndB = streamB[idxB];

    always @(posedge clk) begin
        if (rndEnbA) idxA <= idxA + 9'd1;
        if (rndEnbB) idxB <= idxB + 6'd1;
    end

    function automatic logic [7:0] nextLfsr(input logic [7:0] r);
        return {r[7] ^ r[6] ^ r[5] ^ r[0], r[7:1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: from the current stream position and occupancy, predict every op in the run
    task automatic predictRun(input int sel);
        int          idx;
        int          occ;
        int          depth;
        int          nops;
        logic [7:0]  hi;
        logic [7:0]  lo;
        op_t         e;
        idx   = (sel == 0) ? int'(idxA) : int'(idxB);
        occ   = modelOcc[sel];
        depth = (sel == 0) ? DEPTH_A : DEPTH_B;
        nops  = (sel == 0) ? OPS_A : OPS_B;
        for (int n = 0; n < nops; n++) begin
            hi  = (sel == 0) ? streamA[idx % 512] : streamB[idx % 64];
            lo  = (sel == 0) ? streamA[(idx + 1) % 512] : streamB[(idx + 1) % 64];
            idx = idx + 2;
            e.key = {hi, lo};
            if (occ == 0)          e.isPush = 1'b1;
            else if (occ == depth) e.isPush = 1'b0;
            else                   e.isPush = hi[7];
            occ    = e.isPush ? occ + 1 : occ - 1;
            e.occ  = occ;
            e.cnt  = n + 1;
            e.last = (n == nops - 1);
            if (sel == 0) expA.push_back(e);
            else          expB.push_back(e);
        end
        modelOcc[sel] = occ;
    endtask

    task automatic applyStimulus(input int sel);
        @(posedge clk); #1;
        predictRun(sel);
        if (sel == 0) startA = 1'b1;
        else          startB = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic waitValid(input int sel, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? validA : validB) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(tag, 32'((sel == 0) ? validA : validB), 1);
    endtask

    task automatic waitIdle(input int sel, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!((sel == 0) ? busyA : busyB)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(tag, 32'((sel == 0) ? busyA : busyB), 0);
    endtask

    // Scoreboard for A: compare offered ops at handshake, then the resulting counters one cycle later
    always @(negedge clk) begin
        op_t e;
        if (pendA) begin
            checkOutput("A occupancy after handshake", 32'(occA), 32'(pendOpA.occ));
            checkOutput("A op_count after handshake", 32'(cntA), 32'(pendOpA.cnt));
            checkOutput("A done after handshake", 32'(doneA), 32'(pendOpA.last));
            pendA = 1'b0;
        end
        if (validA && readyA) begin
            if (expA.size() == 0) begin
                checkOutput("A op_valid without expected op", 32'(validA), 0);
            end else begin
                e = expA.pop_front();
                checkOutput("A op_key", 32'(keyA), 32'(e.key));
                checkOutput("A op_push", 32'(pushA), 32'(e.isPush));
                pendOpA = e;
                pendA   = 1'b1;
            end
        end
        if (doneA) doneCntA++;
    end

    // Scoreboard for B, plus the occupancy ceiling and detection of forced pops
    always @(negedge clk) begin
        op_t e;
        if (pendB) begin
            checkOutput("B occupancy after handshake", 32'(occB), 32'(pendOpB.occ));
            checkOutput("B op_count after handshake", 32'(cntB), 32'(pendOpB.cnt));
            checkOutput("B done after handshake", 32'(doneB), 32'(pendOpB.last));
            pendB = 1'b0;
        end
        if (validB && readyB) begin
            if (!pushB && occB == 2'd2 && keyB[15]) obsGuard++;
            if (expB.size() == 0) begin
                checkOutput("B op_valid without expected op", 32'(validB), 0);
            end else begin
                e = expB.pop_front();
                checkOutput("B op_key", 32'(keyB), 32'(e.key));
                checkOutput("B op_push", 32'(pushB), 32'(e.isPush));
                pendOpB = e;
                pendB   = 1'b1;
            end
        end
        if (!rstB) checkOutput("B occupancy bound", 32'(occB <= 2'd2), 1);
        if (doneB) doneCntB++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 512; i++) begin
            streamA[i] = r;
            r = nextLfsr(r);
        end
        r = 8'h01;
        for (int i = 0; i < 64; i++) begin
            streamB[i] = (i < 6) ? r : (8'($urandom) | 8'h80);
            r = nextLfsr(r);
        end
        modelOcc[0] = 0;
        modelOcc[1] = 0;
        rstA = 1'b1; rstB = 1'b1;
        startA = 1'b0; startB = 1'b0;
        readyA = 1'b0; readyB = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("A reset op_valid", 32'(validA), 0);
        checkOutput("A reset rnd_enb", 32'(rndEnbA), 0);
        checkOutput("A reset busy", 32'(busyA), 0);
        checkOutput("A reset done", 32'(doneA), 0);
        checkOutput("A reset occupancy", 32'(occA), 0);
        checkOutput("A reset op_count", 32'(cntA), 0);
        checkOutput("A reset op_key", 32'(keyA), 0);
        checkOutput("A reset op_push", 32'(pushA), 0);
        checkOutput("B reset op_valid", 32'(validB), 0);
        checkOutput("B reset occupancy", 32'(occB), 0);
        rstA = 1'b0; rstB = 1'b0;

        // First op on A: latency, key, forced push, then 10 cycles of backpressure
        applyStimulus(0);
        checkOutput("A op_valid in GET_HI", 32'(validA), 0);
        checkOutput("A rnd_enb in GET_HI", 32'(rndEnbA), 1);
        checkOutput("A busy in GET_HI", 32'(busyA), 1);
        @(posedge clk); #1;
        checkOutput("A op_valid in GET_LO", 32'(validA), 0);
        checkOutput("A rnd_enb in GET_LO", 32'(rndEnbA), 1);
        @(posedge clk); #1;
        checkOutput("A op_valid 3 cycles after start", 32'(validA), 1);
        checkOutput("A first op_key", 32'(keyA), 32'h0180);
        checkOutput("A first op_push forced", 32'(pushA), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("A stall op_valid", 32'(validA), 1);
            checkOutput("A stall op_key", 32'(keyA), 32'h0180);
            checkOutput("A stall op_push", 32'(pushA), 1);
            checkOutput("A stall rnd_enb", 32'(rndEnbA), 0);
            checkOutput("A stall occupancy", 32'(occA), 0);
            checkOutput("A stall op_count", 32'(cntA), 0);
        end
        readyA = 1'b1;
        @(posedge clk); #1;
        readyA = 1'b0;
        checkOutput("A release occupancy", 32'(occA), 1);
        checkOutput("A release op_count", 32'(cntA), 1);
        checkOutput("A op_valid drops after handshake", 32'(validA), 0);
        waitValid(0, "A second op_valid timeout");
        checkOutput("A second op_key", 32'(keyA), 32'hC060);
        checkOutput("A second op_push", 32'(pushA), 1);

        // Reset while an op is being offered
        rstA = 1'b1;
        @(posedge clk); #1;
        rstA = 1'b0;
        checkOutput("A mid-run reset op_valid", 32'(validA), 0);
        checkOutput("A mid-run reset busy", 32'(busyA), 0);
        checkOutput("A mid-run reset occupancy", 32'(occA), 0);
        checkOutput("A mid-run reset op_count", 32'(cntA), 0);
        checkOutput("A mid-run reset op_key", 32'(keyA), 0);
        expA.delete();
        modelOcc[0] = 0;

        // Full 64-op run with stray start pulses that must be ignored
        doneCntA = 0;
        readyA   = 1'b1;
        applyStimulus(0);
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
            startA = (i < 150) && (i % 16 == 3);
        end
        startA = 1'b0;
        checkOutput("A final op_count", 32'(cntA), 32'(OPS_A));
        checkOutput("A done pulse count", 32'(doneCntA), 1);
        checkOutput("A busy after run", 32'(busyA), 0);
        checkOutput("A final occupancy", 32'(occA), 32'(modelOcc[0]));
        checkOutput("A ops left unissued", 32'(expA.size()), 0);

        // Three-op run on B from the LFSR seed
        readyB   = 1'b1;
        doneCntB = 0;
        applyStimulus(1);
        waitValid(1, "B op1 valid timeout");
        checkOutput("B op1 key", 32'(keyB), 32'h0180);
        checkOutput("B op1 push", 32'(pushB), 1);
        waitValid(1, "B op2 valid timeout");
        checkOutput("B op2 key", 32'(keyB), 32'hC060);
        checkOutput("B op2 push", 32'(pushB), 1);
        waitValid(1, "B op3 valid timeout");
        checkOutput("B op3 key", 32'(keyB), 32'h3098);
        checkOutput("B op3 push", 32'(pushB), 0);
        @(posedge clk); #1;
        checkOutput("B done pulse", 32'(doneB), 1);
        @(posedge clk); #1;
        checkOutput("B done clears", 32'(doneB), 0);
        checkOutput("B busy after run", 32'(busyB), 0);
        checkOutput("B occupancy after run", 32'(occB), 1);
        checkOutput("B op_count after run", 32'(cntB), 3);
        checkOutput("B done pulse count", 32'(doneCntB), 1);

        // Further runs on push-biased random bytes drive the queue into its full guard
        for (int r2 = 0; r2 < 5; r2++) begin
            applyStimulus(1);
            waitIdle(1, "B run idle timeout");
        end
        checkOutput("B full guard forced pop seen", 32'(obsGuard > 0), 1);
        checkOutput("B final occupancy", 32'(occB), 32'(modelOcc[1]));
        checkOutput("B total done pulses", 32'(doneCntB), 6);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
